// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-stage load/store unit for the rv32 five-stage pipeline.
// Takes the M-stage access (control, byte address, store data), runs one
// word-addressed valid/grant/rvalid bus transaction per access, and returns an
// aligned, extended load result. The pipeline is stalled while a transaction is
// in flight. Misaligned or illegal accesses are flagged and never reach the bus.
// A transaction stuck in REQ or RESP is aborted after TIMEOUT cycles.
//
// Ports
//   clk_i, rst_i                 clock, async active-high reset
//   lsu_valid_i/we_i/func3_i     M-stage request (held while lsu_stall_o=1)
//   lsu_addr_i, lsu_wdata_i      byte address, store data (low bits)
//   lsu_stall_o                  comb: freeze F/D/E/M
//   lsu_fault_o                  comb: misaligned or illegal func3
//   lsu_rdata_o                  reg: extended load result
//   lsu_err_o                    reg: one-cycle pulse on transaction timeout
//   bus_req_o/we_o/addr_o        reg: bus request, word address
//   bus_wstrb_o/wdata_o          reg: byte strobes, lane-replicated store data
//   bus_gnt_i, bus_rvalid_i      bus grant, load data valid
//   bus_rdata_i                  bus load word

// One byte lane of the store path: strobe and replicated write byte.
module lsu_mem_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size_i,   // func3[1:0]: 0=byte 1=half 2=word
  input  logic [1:0]  off_i,    // byte offset within the word
  input  logic [31:0] wdata_i,
  output logic        strb_o,
  output logic [7:0]  wbyte_o
);
  localparam logic [1:0] L = 2'(LANE);

  always_comb begin
    strb_o  = 1'b1;
    wbyte_o = wdata_i[8*LANE +: 8];
    case (size_i)
      2'd0: begin
        strb_o  = (off_i == L);
        wbyte_o = wdata_i[7:0];
      end
      2'd1: begin
        strb_o  = (off_i[1] == L[1]);
        wbyte_o = wdata_i[8*(LANE%2) +: 8];
      end
      default: ;
    endcase
  end
endmodule

module lsu_mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_valid_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_func3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_fault_o,
  output logic        lsu_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);
  localparam int NUM_LANES = 4;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    func3_q, func3_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // ---------------- access check ----------------
  logic illegal, misal;
  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    case (lsu_func3_i)
      3'b000: ;
      3'b001: misal = lsu_addr_i[0];
      3'b010: misal = |lsu_addr_i[1:0];
      3'b100: illegal = lsu_we_i;          // unsigned variants are load-only
      3'b101: begin
        illegal = lsu_we_i;
        misal   = lsu_addr_i[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign lsu_fault_o = lsu_valid_i & (illegal | misal);
  assign lsu_stall_o = lsu_valid_i & ~lsu_fault_o & (state_q != DONE);

  // ---------------- store lanes ----------------
  logic [NUM_LANES-1:0]      lane_strb;
  logic [NUM_LANES-1:0][7:0] lane_wdata;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_mem_lane #(.LANE(i)) u_lane (
      .size_i  (lsu_func3_i[1:0]),
      .off_i   (lsu_addr_i[1:0]),
      .wdata_i (lsu_wdata_i),
      .strb_o  (lane_strb[i]),
      .wbyte_o (lane_wdata[i])
    );
  end

  // ---------------- load extraction ----------------
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] rext;
  always_comb begin
    rbyte = 8'(bus_rdata_i >> {off_q, 3'b000});
    rhalf = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (func3_q[1:0])
      2'b00:   rext = {{24{~func3_q[2] & rbyte[7]}}, rbyte};
      2'b01:   rext = {{16{~func3_q[2] & rhalf[15]}}, rhalf};
      default: rext = bus_rdata_i;
    endcase
  end

  // Counter reached the last permitted wait cycle in REQ/RESP.
  logic to_hit;
  assign to_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    func3_d = func3_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (lsu_valid_i && !lsu_fault_o) begin
          state_d = REQ;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = lsu_we_i;
          addr_d  = {lsu_addr_i[31:2], 2'b00};
          wstrb_d = lsu_we_i ? lane_strb : 4'b0000;
          wdata_d = lsu_we_i ? lane_wdata : 32'h0;
          func3_d = lsu_func3_i;
          off_d   = lsu_addr_i[1:0];
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        // A grant on the final wait cycle still wins over the timeout.
        if (bus_gnt_i) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = we_q ? DONE : RESP;
        end else if (to_hit) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) rdata_d = '0;
        end
      end
      RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid_i) begin
          rdata_d = rext;
          state_d = DONE;
        end else if (to_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      func3_q <= '0;
      off_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      func3_q <= func3_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wstrb_o = wstrb_q;
  assign bus_wdata_o = wdata_q;
  assign lsu_rdata_o = rdata_q;
  assign lsu_err_o   = err_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;
  localparam int T = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_we;
  logic [2:0]  lsu_func3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_stall, lsu_fault, lsu_err;
  logic [31:0] lsu_rdata;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  always #5 clk = ~clk;

  lsu_mem_stage #(.TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst),
    .lsu_valid_i(lsu_valid), .lsu_we_i(lsu_we), .lsu_func3_i(lsu_func3),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_stall_o(lsu_stall), .lsu_rdata_o(lsu_rdata),
    .lsu_fault_o(lsu_fault), .lsu_err_o(lsu_err),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
    .bus_wstrb_o(bus_wstrb), .bus_wdata_o(bus_wdata),
    .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
  );

  typedef struct { bit fault; bit to; logic [31:0] rdata; int stall_cyc; } done_t;
  typedef struct { bit we; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata; } bus_t;
  typedef struct { bit we; int gd; int rd; int hang; logic [31:0] word; } mem_t;

  done_t done_q[$];
  bus_t  bus_q[$];
  mem_t  mem_q[$];
  int checks = 0, errors = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int fsize(logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit is_fault(bit we, logic [2:0] f, logic [31:0] a);
    bit legal;
    legal = (f == 3'd0 || f == 3'd1 || f == 3'd2) || (!we && (f == 3'd4 || f == 3'd5));
    if (!legal) return 1'b1;
    return (a % fsize(f)) != 0;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f, logic [31:0] a, logic [31:0] word);
    int n;
    longint v, m;
    n = fsize(f);
    m = longint'(1) << (8 * n);
    v = (longint'(word) >> (8 * (a % 4))) & (m - 1);
    if (!f[2] && n < 4 && v >= (m / 2)) v = v - m;
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  task automatic issue(bit we, logic [2:0] f, logic [31:0] a, logic [31:0] wd,
                       logic [31:0] word, int gd, int rd, int hang);
    done_t d;
    bus_t  b;
    mem_t  m;
    bit    flt;
    int    n, k;
    flt = is_fault(we, f, a);
    n = fsize(f);
    d.fault = flt;
    d.to = !flt && (hang != 0);
    if (flt)            d.stall_cyc = 0;
    else if (hang == 1) d.stall_cyc = 1 + T;
    else if (we)        d.stall_cyc = 2 + gd;
    else if (hang == 2) d.stall_cyc = 2 + gd + T;
    else                d.stall_cyc = 3 + gd + rd;
    if (!flt && !we) model_rdata = (hang != 0) ? 32'h0 : exp_load(f, a, word);
    d.rdata = model_rdata;
    if (!flt) begin
      b.we = we;
      b.addr = a - (a % 4);
      b.strb = 4'b0000;
      b.wdata = 32'h0;
      if (we)
        for (int i = 0; i < 4; i++) begin
          b.strb[i] = (i >= a % 4) && (i < a % 4 + n);
          b.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
        end
      bus_q.push_back(b);
      m.we = we; m.gd = gd; m.rd = rd; m.hang = hang; m.word = word;
      mem_q.push_back(m);
    end
    done_q.push_back(d);
    lsu_valid = 1'b1; lsu_we = we; lsu_func3 = f; lsu_addr = a; lsu_wdata = wd;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (lsu_stall && k < 40);
    if (k >= 40) chk("stall_bound", 32'(lsu_stall), 32'h0);
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    lsu_addr = $urandom; lsu_wdata = $urandom; lsu_func3 = 3'($urandom);
  endtask

  // ---------------- bus responder ----------------
  initial begin : responder
    mem_t m;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      bus_rvalid = 1'b0;
      bus_rdata = $urandom;
      if (rst) continue;
      if (bus_req && mem_q.size() > 0) begin
        m = mem_q.pop_front();
        if (m.hang == 1) begin
          for (int i = 0; i < T + 4 && bus_req; i++) @(negedge clk);
        end else begin
          repeat (m.gd) @(negedge clk);
          bus_gnt = 1'b1;
          @(negedge clk);
          bus_gnt = 1'b0;
          if (!m.we && m.hang == 0) begin
            repeat (m.rd) @(negedge clk);
            bus_rvalid = 1'b1;
            bus_rdata = m.word;
          end
        end
      end else if (!lsu_valid || !lsu_stall) begin
        // stray rvalid while no load is waiting for data
        bus_rvalid = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    done_t d;
    bus_t  b;
    int    sc;
    bit    req_seen;
    sc = 0;
    req_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sc = 0;
        req_seen = 1'b0;
        continue;
      end
      if (bus_req && !req_seen) begin
        req_seen = 1'b1;
        if (bus_q.size() == 0) chk("bus_unexpected_req", 32'(bus_req), 32'h0);
        else begin
          b = bus_q.pop_front();
          chk("bus_we", 32'(bus_we), 32'(b.we));
          chk("bus_addr", bus_addr, b.addr);
          chk("bus_wstrb", 32'(bus_wstrb), 32'(b.strb));
          if (b.we) chk("bus_wdata", bus_wdata, b.wdata);
        end
      end
      if (!bus_req) req_seen = 1'b0;
      if (lsu_valid && lsu_stall) sc++;
      else if (lsu_valid) begin
        if (done_q.size() == 0) chk("unexpected_completion", 32'(lsu_valid), 32'h0);
        else begin
          d = done_q.pop_front();
          chk("fault", 32'(lsu_fault), 32'(d.fault));
          chk("stall_cycles", 32'(sc), 32'(d.stall_cyc));
          chk("lsu_err", 32'(lsu_err), 32'(d.to));
          chk("lsu_rdata", lsu_rdata, d.rdata);
          if (d.fault) chk("fault_no_req", 32'(bus_req), 32'h0);
        end
        sc = 0;
      end else begin
        chk("idle_err", 32'(lsu_err), 32'h0);
        chk("idle_req", 32'(bus_req), 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    bit we;
    logic [2:0] f;
    int hang;
    rst = 1'b1;
    lsu_valid = 1'b0; lsu_we = 1'b0; lsu_func3 = 3'd0;
    lsu_addr = 32'h0; lsu_wdata = 32'h0;
    #12;
    chk("rst_req", 32'(bus_req), 32'h0);
    chk("rst_we", 32'(bus_we), 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wstrb", 32'(bus_wstrb), 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_rdata", lsu_rdata, 32'h0);
    chk("rst_err", 32'(lsu_err), 32'h0);
    chk("rst_stall", 32'(lsu_stall), 32'h0);
    chk("rst_fault", 32'(lsu_fault), 32'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // directed
    issue(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);      // SW
    issue(1, 3'b000, 32'h103, 32'h000000A5, 0, 1, 0, 0);      // SB
    issue(1, 3'b001, 32'h102, 32'h1234BEEF, 0, 0, 0, 0);      // SH
    issue(0, 3'b000, 32'h101, 0, 32'h00008000, 0, 0, 0);      // LB
    issue(0, 3'b100, 32'h101, 0, 32'h00008000, 0, 0, 0);      // LBU
    issue(0, 3'b101, 32'h102, 0, 32'hBEEF0000, 0, 0, 0);      // LHU
    issue(0, 3'b010, 32'h102, 0, 0, 0, 0, 0);                 // LW misaligned
    issue(0, 3'b001, 32'h101, 0, 0, 0, 0, 0);                 // LH misaligned
    issue(0, 3'b011, 32'h100, 0, 0, 0, 0, 0);                 // illegal func3
    issue(1, 3'b100, 32'h100, 0, 0, 0, 0, 0);                 // store with unsigned code
    issue(0, 3'b010, 32'h104, 0, 32'h12345678, 3, 2, 0);      // slow load
    repeat (6) @(posedge clk); #1;                            // stray rvalid in IDLE
    issue(1, 3'b010, 32'h108, 32'h0BADF00D, 0, 0, 0, 0);      // rdata must be unchanged
    issue(1, 3'b010, 32'h10C, 32'h11111111, 0, 0, 0, 1);      // REQ timeout, store
    issue(0, 3'b001, 32'h10E, 0, 32'h8001_0000, 0, 0, 0);     // LH sign extend
    issue(0, 3'b010, 32'h110, 0, 32'h55555555, 0, 0, 1);      // REQ timeout, load
    issue(0, 3'b000, 32'h113, 0, 32'h7F000000, 1, 1, 0);
    issue(0, 3'b010, 32'h114, 0, 32'h55555555, 2, 0, 2);      // RESP timeout

    // randomized
    for (int n = 0; n < 250; n++) begin
      we = 1'($urandom);
      f = 3'($urandom);
      hang = ($urandom_range(0, 15) == 0) ? (we ? 1 : int'($urandom_range(1, 2))) : 0;
      issue(we, f, $urandom, $urandom, $urandom, $urandom_range(0, 4),
            $urandom_range(0, 4), hang);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // reset in RESP
    issue(0, 3'b010, 32'h200, 0, 32'hCAFEF00D, 0, 0, 0);
    begin
      bus_t b;
      mem_t m;
      b.we = 1'b0; b.addr = 32'h204; b.strb = 4'b0000; b.wdata = 32'h0;
      bus_q.push_back(b);
      m.we = 1'b0; m.gd = 0; m.rd = 0; m.hang = 2; m.word = 32'h0;
      mem_q.push_back(m);
    end
    lsu_valid = 1'b1; lsu_we = 1'b0; lsu_func3 = 3'b010; lsu_addr = 32'h204;
    repeat (4) @(negedge clk);
    #2;
    chk("resp_req_low", 32'(bus_req), 32'h0);
    chk("resp_rdata_held", lsu_rdata, 32'hCAFEF00D);
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(bus_req), 32'h0);
    chk("midrst_rdata", lsu_rdata, 32'h0);
    chk("midrst_err", 32'(lsu_err), 32'h0);
    lsu_valid = 1'b0;
    model_rdata = 32'h0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue(0, 3'b101, 32'h302, 0, 32'hFFFF0000, 1, 1, 0);
    issue(1, 3'b000, 32'h301, 32'h5A, 0, 0, 0, 0);

    repeat (5) @(posedge clk);
    chk("done_q_empty", 32'(done_q.size()), 32'h0);
    chk("bus_q_empty", 32'(bus_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
